mux_scan_nch: RTL and testbench

//  Registered N-channel, WAYS:1 data selector with per-channel active-low output enables.

---
 rtl/mux_scan_pkg.sv | 7 +
 rtl/mux_scan_ctr.sv | 35 +++
 rtl/mux_scan_nch.sv | 66 ++++++
 tb/tb_mux_scan_nch.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state type and select-width helper for the scan selector.
package mux_scan_pkg;
    typedef enum logic {MANUAL, SCAN} scan_state_t;
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mux_scan_ctr.sv
// mux_scan_ctr: dwell counter plus loadable index counter with a registered wrap pulse.
module mux_scan_ctr
    import mux_scan_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int DWELL = 4,
    parameter int SEL_W = sel_width(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ld,
    input  logic [SEL_W-1:0] ld_val,
    output logic [SEL_W-1:0] sel,
    output logic             wrap
);
    localparam int DW = sel_width(DWELL);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(WAYS - 1);
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
    logic [DW-1:0] dwell_cnt;
    logic          step;
    assign step = en && dwell_cnt == DLAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
            sel       <= '0;
            wrap      <= 1'b0;
        end else begin
            dwell_cnt <= (clr || step) ? '0 : en ? dwell_cnt + 1'b1 : dwell_cnt;
            sel       <= ld ? ld_val : step ? (sel == LAST ? '0 : sel + 1'b1) : sel;
            wrap      <= step && sel == LAST;
        end
    end
endmodule

// File: rtl/mux_scan_nch.sv
// mux_scan_nch: registered CH-channel WAYS:1 selector, manual or dwell-scan indexed.
// Define MUX_TRISTATE_EN to float disabled Y bits instead of forcing them low.
module mux_scan_nch
    import mux_scan_pkg::*;
#(
    parameter int CH    = 2,
    parameter int WAYS  = 4,
    parameter int SEL_W = sel_width(WAYS),
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WAYS-1:0]  D,
    input  logic [CH-1:0]       G_n,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel_in,
    input  logic                load,
    output logic [CH-1:0]       Y,
    output logic [CH-1:0]       Y_oe,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                wrap
);
    scan_state_t      state;
    logic [SEL_W-1:0] sel_q;
    logic [CH-1:0]    y_nxt, y_q;
    logic             scan_clr, scan_en, ld;
    // a mode request in either state pre-empts any load in the same cycle
    assign scan_clr = state == MANUAL && mode;
    assign scan_en  = state == SCAN && mode;
    assign ld       = state == MANUAL && !mode && load && int'(sel_in) < WAYS;
    mux_scan_ctr #(.WAYS(WAYS), .DWELL(DWELL), .SEL_W(SEL_W)) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (scan_clr),
        .en     (scan_en),
        .ld     (ld),
        .ld_val (sel_in),
        .sel    (sel_q),
        .wrap   (wrap)
    );
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [WAYS-1:0] ways;
        assign ways     = D[c*WAYS +: WAYS];
        assign y_nxt[c] = ways[sel_q];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MANUAL;
            y_q     <= '0;
            Y_oe    <= '0;
            cur_sel <= '0;
        end else begin
            state   <= mode ? SCAN : MANUAL;
            y_q     <= y_nxt;
            Y_oe    <= ~G_n;
            cur_sel <= sel_q;
        end
    end
`ifdef MUX_TRISTATE_EN
    for (genvar c = 0; c < CH; c++) begin : g_tri
        assign Y[c] = Y_oe[c] ? y_q[c] : 1'bz;
    end
`else
    assign Y = y_q & Y_oe;
`endif
endmodule

// File: tb/tb_mux_scan_nch.sv
// tb_mux_scan_nch: directed plus random checks of mux_scan_nch against an index-arithmetic model.
module tb_mux_scan_nch;
    localparam int CH = 2, WAYS = 4, DWELL = 4, SEL_W = 2;
`ifdef MUX_TRISTATE_EN
    localparam logic OFF = 1'bz;
`else
    localparam logic OFF = 1'b0;
`endif
    logic clk = 1'b0, rst, mode, load, wrap;
    logic [CH*WAYS-1:0] D;
    logic [CH-1:0]      G_n, Y, Y_oe, e_y, e_oe;
    logic [SEL_W-1:0]   sel_in, cur_sel;
    logic               e_wrap;
    int compared = 0, mismatched = 0;
    int e_cur, wraps;
    bit m_scan;
    int m_base, m_ticks;

    mux_scan_nch #(.CH(CH), .WAYS(WAYS), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .D(D), .G_n(G_n), .mode(mode), .sel_in(sel_in),
        .load(load), .Y(Y), .Y_oe(Y_oe), .cur_sel(cur_sel), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // scan index = start index advanced once per DWELL enabled scan cycles
    function automatic int m_sel();
        return m_scan ? (m_base + m_ticks / DWELL) % WAYS : m_base;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        int s;
        @(posedge clk);
        s = m_sel();
        for (int c = 0; c < CH; c++)
            e_y[c] = (rst || G_n[c]) ? OFF : D[c*WAYS+s];
        e_oe   = rst ? '0 : ~G_n;
        e_cur  = rst ? 0 : s;
        e_wrap = 1'b0;
        if (rst) begin
            m_scan = 0; m_base = 0; m_ticks = 0;
        end else if (!m_scan) begin
            if (mode) begin
                m_scan = 1; m_ticks = 0;
            end else if (load && int'(sel_in) < WAYS) m_base = int'(sel_in);
        end else if (!mode) begin
            m_base = s; m_scan = 0; m_ticks = 0;
        end else begin
            m_ticks++;
            e_wrap = (m_ticks % DWELL == 0) && m_sel() == 0;
        end
        @(negedge clk);
        check("y", Y, e_y);
        check("y_oe", Y_oe, e_oe);
        check("cur_sel", cur_sel, e_cur);
        check("wrap", wrap, e_wrap);
    endtask

    initial begin
        m_scan = 0; m_base = 0; m_ticks = 0;
        rst = 1; D = '1; G_n = '0; mode = 0; load = 0; sel_in = '0;
        @(negedge clk);
        step(); step();
        check("rst_y", Y, {CH{OFF}});
        check("rst_cur_sel", cur_sel, 0);
        rst = 0; D = 8'b1010_0110; load = 1; sel_in = 2;
        step();
        load = 0;
        step();
        check("t2_cur_sel", cur_sel, 2);
        check("t2_y", Y, 2'b01);
        mode = 1; wraps = 0;
        repeat (32) begin
            step();
            wraps += int'(wrap);
        end
        check("t3_wraps", wraps, 2);
        for (int i = 0; i < 40 && !(m_scan && m_sel() == 3); i++) step();
        mode = 0; load = 1; sel_in = 1;
        step();
        load = 0;
        step();
        check("t4_frozen", cur_sel, 3);
        load = 1; sel_in = 1;
        step();
        load = 0;
        step();
        check("t4_load", cur_sel, 1);
        G_n = 2'b10;
        step(); step();
        check("t5_oe", Y_oe, 2'b01);
        check("t5_y1", Y[1], OFF);
        G_n = '0; mode = 1;
        for (int i = 0; i < 40 && !(m_scan && m_sel() == 2 && m_ticks % DWELL == 3); i++) step();
        rst = 1;
        step();
        check("t6_rst_oe", Y_oe, 0);
        check("t6_rst_cur", cur_sel, 0);
        rst = 0;
        repeat (5) step();
        check("t6_full_dwell", cur_sel, 0);
        step();
        check("t6_advance", cur_sel, 1);
        repeat (400) begin
            rst    = ($urandom_range(0, 49) == 0);
            mode   = ($urandom_range(0, 7) == 0) ? ~mode : mode;
            load   = $urandom_range(0, 1);
            sel_in = SEL_W'($urandom);
            D      = (CH*WAYS)'($urandom);
            G_n    = CH'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
